barrett_modred_engine: RTL
==========================

Name: barrett_modred_engine

Overview:
Streaming Barrett modular reducer computing r = a mod p for a 2W-bit operand and a W-bit modulus that is programmable at run time. It is the next generation of our fixed-modulus Barrett reducer and the modular-reduction primitive for the MSM field-arithmetic datapath. On reset and on every reconfiguration, a serial divider computes mu = floor(2^(2W)/p) in hardware. A 3-stage valid/ready pipeline then accepts one operand per cycle.

Parameters:
W, 128, modulus width; operands are 2W bits.
DEFAULT_P, 37, modulus loaded at reset; must satisfy 2 <= DEFAULT_P < 2^W.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-low reset.
cfg_valid  in  1  request to load a new modulus.
cfg_ready  out  1  engine can accept a new modulus.
cfg_p  in  W  new modulus.
cfg_err  out  1  one-cycle pulse: cfg_p < 2 was rejected.
busy  out  1  mu computation in progress.
in_valid  in  1  operand valid.
in_ready  out  1  operand accepted when in_valid && in_ready.
in_a  in  2W  operand a, full range 0..2^(2W)-1.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_r  out  W  a mod p.

Behaviour:
- Interface: clk and reset are the only clock and reset. reset is synchronous and active-low: sampled only on the rising edge of clk, and asserted when low.
- Reset (reset == 0):
  - p = DEFAULT_P; FSM enters DIV with the iteration counter at 0.
  - All pipeline valid bits are cleared.
  - Output values: busy = 1, out_valid = 0, in_ready = 0, cfg_ready = 0, cfg_err = 0, out_r = 0.
  - Reset asserted mid-division or mid-stream aborts all work; the in-flight results are discarded and never presented.
- FSM states:
  - DIV: restoring division of 2^(2W) by p, one quotient bit per cycle, 2W+1 cycles total.
    - busy = 1, in_ready = 0, cfg_ready = 0.
    - On the final iteration, mu (2W bits) is latched and the FSM moves to RUN.
    - After reset is released, busy falls exactly 2W+1 cycles later.
  - RUN: busy = 0. cfg_ready = 1 only when all three pipeline stages are empty and out_valid = 0; no operand is ever reduced with a mixed modulus.
  - cfg_valid && cfg_ready with cfg_p >= 2: latch p, clear mu, go to DIV.
  - cfg_valid && cfg_ready with cfg_p < 2: cfg_err pulses for 1 cycle, p and mu are unchanged, and the FSM stays in RUN.
  - cfg_valid while cfg_ready = 0 is ignored. There is no queuing; the requester holds cfg_valid until cfg_ready is seen.
- Pipeline: advance = !out_valid || out_ready; in_ready = (state == RUN) && advance.
  - S1: register a; compute P = a * mu (4W bits).
  - S2: q = P >> 2W (at most 2W bits); t = a - q*p, computed modulo 2^(W+2).
  - S3: the estimate satisfies t < 3p. Apply two conditional subtractions, giving r in [0, p-1]; register out_r and set out_valid.
  - Latency is 3 cycles from acceptance to out_valid when unstalled. Throughput is 1 result per cycle.
  - When advance = 0, every stage holds and out_r stays stable.
  - Results leave in acceptance order.
- Arithmetic: every product and difference is sized explicitly with no silent truncation. The only exception is t, which is held in W+2 bits, enough to represent values below 3p < 2^(W+2).

Decomposition:
- barrett_pkg:
  - FSM state enum (DIV, RUN).
  - Width helpers: MU_W = 2W, PROD_W = 4W, T_W = W+2.
  - Division iteration count DIV_CYCLES = 2W+1.
- Sub-module barrett_mu_divider: serial restoring divider with start, busy, done, and mu outputs; the engine instantiates it once.

Test Plan:
1. Reset, then wait for busy to fall. Check busy fell exactly 2W+1 cycles after reset release. Send a = 10*37+12 = 382 -> out_r = 12, with out_valid 3 cycles after acceptance.
2. Reconfigure cfg_p = 2^127-1 (W = 128). Check busy is high for 257 cycles. Send a = 2^256-1 -> out_r = 3. Send a = 2^127-1 -> 0. Send a = 2^127 -> 1.
3. Reconfigure cfg_p = 0 and cfg_p = 1 -> cfg_err pulses once each, busy stays 0, and a = 382 still gives 12 (p = 37).
4. Stream 100 random operands with out_ready toggled randomly -> every out_r matches a mod p, in order. out_r holds while out_valid && !out_ready. No operand is lost or duplicated.
5. Assert cfg_valid with 3 operands in flight -> cfg_ready stays 0 until all 3 results drain; the new p takes effect only for operands accepted afterwards.
6. Drive reset low mid-DIV and mid-stream -> out_valid = 0 immediately after reset. mu is recomputed for DEFAULT_P, and a = 382 -> 12.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared types and width helpers for the Barrett modular reduction engine.
package barrett_pkg;

    typedef enum logic {StDiv, StRun} state_e;

    function automatic int unsigned mu_w(input int unsigned w);
        return 2 * w;
    endfunction

    function automatic int unsigned prod_w(input int unsigned w);
        return 4 * w;
    endfunction

    function automatic int unsigned t_w(input int unsigned w);
        return w + 2;
    endfunction

    function automatic int unsigned div_cycles(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/barrett_mu_divider.sv
// Serial restoring divider producing mu = floor(2^(2W) / p), one quotient bit per cycle.
module barrett_mu_divider
    import barrett_pkg::*;
#(
    parameter int unsigned W = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   p,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] mu
);

    localparam int unsigned MU_W       = mu_w(W);
    localparam int unsigned DIV_CYCLES = div_cycles(W);
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_CYCLES - 1);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     rem_q;
    logic [MU_W-2:0]  q_q;
    logic [MU_W-1:0]  mu_q;

    logic             ge;
    logic [W:0]       rem_sh;
    logic [W-1:0]     rem_d;
    logic [MU_W-1:0]  q_d;

    // Dividend 2^(2W) has only its top bit set, which is consumed on iteration 0.
    always_comb begin
        rem_sh = {rem_q, cnt_q == '0};
        ge     = rem_sh >= {1'b0, p};
        rem_d  = ge ? W'(rem_sh - {1'b0, p}) : rem_sh[W-1:0];
        q_d    = {q_q, ge};
    end

    assign busy = run_q;
    assign done = run_q && (cnt_q == LAST);
    assign mu   = mu_q;

    always_ff @(posedge clk) begin
        if (!reset || start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            rem_q <= '0;
            q_q   <= '0;
            mu_q  <= '0;
        end else if (run_q) begin
            rem_q <= rem_d;
            q_q   <= q_d[MU_W-2:0];
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
                mu_q  <= q_d;
            end
        end
    end

endmodule

// File: rtl/barrett_modred_engine.sv
// Streaming Barrett reducer r = a mod p with a run-time programmable modulus.
module barrett_modred_engine
    import barrett_pkg::*;
#(
    parameter int unsigned  W         = 128,
    parameter logic [W-1:0] DEFAULT_P = W'(37)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [W-1:0]   cfg_p,
    output logic           cfg_err,
    output logic           busy,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_r
);

    localparam int unsigned MU_W   = mu_w(W);
    localparam int unsigned PROD_W = prod_w(W);
    localparam int unsigned T_W    = t_w(W);
    localparam int unsigned QP_W   = 3 * W;

    state_e          state_q, state_d;
    logic [W-1:0]    p_q, p_d;
    logic            cfg_err_q, cfg_err_d;
    logic            div_start, div_done;
    logic [MU_W-1:0] mu;

    logic            advance, accept, pipe_empty;
    logic            v1_q, v2_q, v3_q, out_valid_q;
    logic [MU_W-1:0] a1_q, q2_q;
    logic [T_W-1:0]  a2_q, t3_q;
    logic [W-1:0]    out_r_q;

    logic [PROD_W-1:0] prod;
    logic [MU_W-1:0]   q_d;
    logic [QP_W-1:0]   qp;
    logic [T_W-1:0]    t_d, p_ext, r1, r2;

    barrett_mu_divider #(
        .W(W)
    ) u_mu_div (
        .clk  (clk),
        .reset(reset),
        .start(div_start),
        .p    (p_q),
        .busy (busy),
        .done (div_done),
        .mu   (mu)
    );

    assign advance    = !out_valid_q || out_ready;
    assign in_ready   = (state_q == StRun) && advance;
    assign accept     = in_valid && in_ready;
    assign pipe_empty = !v1_q && !v2_q && !v3_q && !out_valid_q;
    // Gating on in_valid keeps an operand and a new modulus from landing on the same edge.
    assign cfg_ready  = (state_q == StRun) && pipe_empty && !in_valid;
    assign cfg_err    = cfg_err_q;
    assign out_valid  = out_valid_q;
    assign out_r      = out_r_q;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        cfg_err_d = 1'b0;
        div_start = 1'b0;
        unique case (state_q)
            StDiv: begin
                if (div_done) state_d = StRun;
            end
            StRun: begin
                if (cfg_valid && cfg_ready) begin
                    if (cfg_p < W'(2)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        p_d       = cfg_p;
                        div_start = 1'b1;
                        state_d   = StDiv;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StDiv;
            p_q       <= DEFAULT_P;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // t only needs the low W+2 bits since the true difference is below 3p.
    always_comb begin
        prod  = PROD_W'(a1_q) * PROD_W'(mu);
        q_d   = MU_W'(prod >> MU_W);
        qp    = QP_W'(q2_q) * QP_W'(p_q);
        t_d   = T_W'(QP_W'(a2_q) - qp);
        p_ext = T_W'(p_q);
        r1    = (t3_q >= p_ext) ? t3_q - p_ext : t3_q;
        r2    = (r1 >= p_ext) ? r1 - p_ext : r1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
        end else if (advance) begin
            v1_q        <= accept;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            out_valid_q <= v3_q;
            if (v3_q) out_r_q <= W'(r2);
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a1_q <= in_a;
            q2_q <= q_d;
            a2_q <= a1_q[T_W-1:0];
            t3_q <= t_d;
        end
    end

endmodule
